// File: rtl/labfinal_soc_debug_pkg.sv
// Shared types and jdo field positions for the ocimem debug sequencer.
package labfinal_soc_debug_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2
  } ocimem_state_e;

  localparam int unsigned JDO_ADDR_LSB   = 17;
  localparam int unsigned JDO_RDREQ_BIT  = 34;
  localparam int unsigned JDO_CLRERR_BIT = 35;
  localparam int unsigned JDO_WDATA_MSB  = 34;
  localparam int unsigned JDO_WDATA_LSB  = 3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/labfinal_soc_debug_stall_timer.sv
// Stall counter: cleared while idle, counts stalled cycles, flags the cycle that hits the limit.
module labfinal_soc_debug_stall_timer #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [7:0] count_q, count_d;

  // Expiry fires on the Limit-th stalled cycle so the request drops right after it.
  assign expired = inc && (count_q == 8'(Limit - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/labfinal_soc_debug_ocimem_seq.sv
// Turns ocimem strobes and jdo into single-word Avalon-MM accesses with status back to JTAG.
module labfinal_soc_debug_ocimem_seq
  import labfinal_soc_debug_pkg::*;
#(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic [1:0]        avm_response,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  ocimem_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mon_q, mon_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              no_inc_q, no_inc_d;
  logic              expired;
  logic              any_strobe;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  labfinal_soc_debug_stall_timer #(
    .Limit (TIMEOUT)
  ) u_stall_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == StIdle),
    .inc     ((state_q != StIdle) && avm_waitrequest),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    mon_d    = mon_q;
    wdata_d  = wdata_q;
    ready_d  = ready_q;
    error_d  = error_q;
    read_d   = read_q;
    write_d  = write_q;
    no_inc_d = no_inc_q;
    unique case (state_q)
      StIdle: begin
        if (take_action_ocimem_a) begin
          addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
          if (jdo[JDO_CLRERR_BIT]) error_d = 1'b0;
          if (jdo[JDO_RDREQ_BIT]) begin
            read_d   = 1'b1;
            no_inc_d = 1'b1;
            ready_d  = 1'b0;
            state_d  = StRd;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          write_d  = 1'b1;
          no_inc_d = 1'b0;
          ready_d  = 1'b0;
          state_d  = StWr;
        end else if (take_no_action_ocimem_a) begin
          read_d   = 1'b1;
          no_inc_d = 1'b0;
          ready_d  = 1'b0;
          state_d  = StRd;
        end
      end
      StRd, StWr: begin
        // Overrun: strobe is dropped but flagged; the transfer in flight carries on.
        if (any_strobe) error_d = 1'b1;
        if (!avm_waitrequest) begin
          if (avm_response != RESP_OKAY) error_d = 1'b1;
          if (state_q == StRd) begin
            mon_d = (avm_response == RESP_OKAY) ? avm_readdata : ERR_DATA;
          end
          if (!no_inc_q) addr_d = addr_q + 1'b1;
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          state_d = StIdle;
        end else if (expired) begin
          error_d = 1'b1;
          if (state_q == StRd) mon_d = ERR_DATA;
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      mon_q    <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b1;
      error_q  <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      no_inc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      mon_q    <= mon_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
      read_q   <= read_d;
      write_q  <= write_d;
      no_inc_q <= no_inc_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign MonDReg        = mon_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: doc/labfinal_soc_debug_ocimem_seq.md
Name: labfinal_soc_debug_ocimem_seq

Overview:
Downstream consumer of the debug-slave system-clock stage. Decodes the ocimem command strobes and the 38-bit jdo word into word accesses on an Avalon-MM master that reaches the debug/system memory. Returns read data and status (MonDReg, monitor_ready, monitor_error), which the JTAG-side shift logic captures. Supports single reads and writes, plus auto-incrementing streaming reads and writes.

Parameters:
ADDR_W, 9, word-address width of avm_address; jdo address field width.
TIMEOUT, 255, max cycles a request may stall on waitrequest before abort (8-bit counter, 1..255).
ERR_DATA, 32'hDEADBEEF, value loaded into MonDReg on an aborted or errored read.

Ports:
clk  in  1  system clock (same domain as jdo / take_action_* strobes)
reset  in  1  asynchronous, active-high reset
jdo  in  38  command/data word, stable in the strobe cycle
take_action_ocimem_a  in  1  1-cycle strobe: load address/flags
take_action_ocimem_b  in  1  1-cycle strobe: write jdo[34:3] at addr, then addr+1
take_no_action_ocimem_a  in  1  1-cycle strobe: read at addr, then addr+1
avm_address  out  ADDR_W  word address
avm_read  out  1  read request
avm_write  out  1  write request
avm_writedata  out  32  write data
avm_byteenable  out  4  constant 4'hF
avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest
avm_waitrequest  in  1  slave stall
avm_response  in  2  00 = OKAY; any other value = error; sampled at completion
MonDReg  out  32  last read data
monitor_ready  out  1  high when idle and last command completed
monitor_error  out  1  sticky error flag
busy  out  1  state != IDLE

Behaviour:
- Reset values: addr_reg=0, MonDReg=0, monitor_ready=1, monitor_error=0, avm_read=avm_write=0, avm_writedata=0, state=IDLE, timeout counter=0.
- Three states: IDLE, RD, WR. busy = (state != IDLE).
- Strobe priority when more than one is asserted in the same cycle: ocimem_a > ocimem_b > no_action_ocimem_a. Lower-priority strobes are ignored.
- ocimem_a in IDLE:
  - addr_reg <= jdo[ADDR_W+16:17].
  - If jdo[35]=1, clear monitor_error.
  - If jdo[34]=1, start a read at the new address (-> RD); addr_reg does not increment after this read.
  - Otherwise stay IDLE; monitor_ready unchanged.
- ocimem_b in IDLE: avm_writedata <= jdo[34:3], avm_write=1, -> WR.
- no_action_ocimem_a in IDLE: avm_read=1, -> RD.
- monitor_ready drops in the cycle after any accepted access strobe.
- Requests hold address, data and control until the first cycle with waitrequest=0; that cycle completes the transfer. Minimum latency is strobe -> request asserted next cycle -> completion that same cycle if waitrequest=0 -> monitor_ready=1 one cycle later.
- Read completion:
  - MonDReg <= avm_readdata if response==00.
  - Otherwise MonDReg <= ERR_DATA and monitor_error <= 1.
- Write completion: if response != 00, monitor_error <= 1.
- After any completion:
  - addr_reg <= addr_reg+1, modulo 2^ADDR_W, so all-ones wraps to 0. The ocimem_a-launched read is the one exception (no increment).
  - Go to IDLE with monitor_ready=1.
- Timeout: the counter resets to 0 on entry to RD/WR and increments each stalled cycle. On reaching TIMEOUT:
  - deassert the request;
  - monitor_error <= 1;
  - a read loads MonDReg <= ERR_DATA;
  - no address increment;
  - go to IDLE, monitor_ready=1.
- Overrun: any strobe while busy is dropped and sets monitor_error. The in-flight transfer is unaffected.
- Async reset mid-transfer: request deasserted immediately; all registers return to reset values.
- Outputs are registered; no combinational path from the avm_* inputs to the avm_* outputs.

Decomposition:
- Shared package labfinal_soc_debug_pkg holds:
  - state enum (IDLE, RD, WR);
  - jdo field constants: JDO_ADDR_LSB=17, JDO_RDREQ_BIT=34, JDO_CLRERR_BIT=35, JDO_WDATA_MSB=34, JDO_WDATA_LSB=3;
  - RESP_OKAY=2'b00.
- One natural sub-module: labfinal_soc_debug_stall_timer (loadable 8-bit stall counter with an expiry flag).

Test Plan:
- Reset mid-write: assert reset while WR with waitrequest=1 -> avm_write=0 in the same cycle; after release MonDReg=0, monitor_ready=1, monitor_error=0, avm_address=0.
- Single read: ocimem_a with addr=0x010, jdo[34]=1; slave returns 0x12345678 with 2 waitrequest cycles -> avm_read high 3 cycles at 0x010; MonDReg=0x12345678; monitor_ready=1; addr_reg stays 0x010.
- Streaming write and wrap: ocimem_a addr=0x1FE, then ocimem_b ×3 with data 0xA, 0xB, 0xC -> writes land at 0x1FE, 0x1FF, 0x000; addr_reg ends at 0x001; no error.
- Error response: no_action read with response=2'b10 -> MonDReg=0xDEADBEEF, monitor_error=1. A subsequent ocimem_a with jdo[35]=1 clears monitor_error.
- Timeout: TIMEOUT=4, hold waitrequest=1 -> avm_read drops after exactly 4 stall cycles; monitor_error=1; MonDReg=0xDEADBEEF; addr_reg unchanged.
- Overrun and priority: ocimem_b pulsed while RD is stalled -> no write issued, monitor_error=1. In IDLE, ocimem_a and ocimem_b asserted together -> only the address is loaded, no write.
